// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 width codes, response
// codes, FSM states and lane helpers.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] WIDTH_B  = 3'b000;
  localparam logic [2:0] WIDTH_H  = 3'b001;
  localparam logic [2:0] WIDTH_W  = 3'b010;
  localparam logic [2:0] WIDTH_BU = 3'b100;
  localparam logic [2:0] WIDTH_HU = 3'b101;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Illegal width code, or an access that straddles its natural alignment.
  function automatic logic access_fault(input logic [2:0] width, input logic [1:0] a);
    case (width)
      WIDTH_B, WIDTH_BU: access_fault = 1'b0;
      WIDTH_H, WIDTH_HU: access_fault = a[0];
      WIDTH_W:           access_fault = (a != 2'b00);
      default:           access_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [2:0] width, input logic [1:0] a);
    case (width)
      WIDTH_B, WIDTH_BU: lane_strobe = 4'b0001 << a;
      WIDTH_H, WIDTH_HU: lane_strobe = 4'b0011 << a;
      default:           lane_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] width, input logic [31:0] d);
    case (width)
      WIDTH_B, WIDTH_BU: lane_replicate = {4{d[7:0]}};
      WIDTH_H, WIDTH_HU: lane_replicate = {2{d[15:0]}};
      default:           lane_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_ld_align_ext.sv
// Load data aligner: shifts the addressed byte/half down to bit 0 and applies
// sign or zero extension according to the funct3 width code.
module ld_align_ext
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_width,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_width)
      WIDTH_B:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      WIDTH_H:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      WIDTH_BU: o_data = {24'h0, w_shifted[7:0]};
      WIDTH_HU: o_data = {16'h0, w_shifted[15:0]};
      default:  o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory port: one access
// per handshake, alignment checking, lane strobes, load extension and a bus timeout.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  state_e      w_next_state;
  logic        r_we;
  logic [2:0]  r_width;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_data;
  logic [1:0]  r_resp_err;
  logic [15:0] r_cnt;

  logic        w_fault;
  logic        w_timeout;
  logic [31:0] w_ld_data;

  assign w_fault   = access_fault(req_width, req_addr[1:0]);
  assign w_timeout = (r_cnt == CNT_LAST);

  ld_align_ext u_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_width   (r_width),
    .o_data    (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The awaited memory event is tested before the timeout so it wins a tie.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next_state = w_fault ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          w_next_state = r_we ? ST_DONE : ST_WAIT;
        end else if (w_timeout) begin
          w_next_state = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid || w_timeout) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_width     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= ERR_OK;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_width     <= req_width;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_resp_data <= '0;
            r_resp_err  <= w_fault ? ERR_ALIGN : ERR_OK;
            r_cnt       <= '0;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + 16'd1;
          if (!mem_ready && w_timeout) begin
            r_resp_err <= ERR_TIMEOUT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem_rvalid) begin
            r_resp_data <= w_ld_data;
          end else if (w_timeout) begin
            r_resp_err <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign mem_valid  = (r_state == ST_REQ);
  assign mem_we     = r_we;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wstrb  = r_we ? lane_strobe(r_width, r_addr[1:0]) : 4'b0000;
  assign mem_wdata  = lane_replicate(r_width, r_wdata);
  assign resp_valid = (r_state == ST_DONE);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, randomized accesses
// against an arithmetic reference model, and reset / back-to-back sequences.
module tb_lsu_mem_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_width  (req_width),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy;
    int          rv;
    int          lat;
    logic [1:0]  err;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] wexp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expectations from byte counts, arithmetic shifts and a cycle budget.
  function automatic vec_t ref_model(input logic we, input logic [2:0] width,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [31:0] rdata, input int rdy, input int rv);
    vec_t e;
    int nbytes, a, need, wcode;
    logic [31:0] v;
    e = '{we, width, addr, wdata, rdata, rdy, rv, 0, 2'b00, 32'h0, 4'h0, 32'h0};
    wcode = int'(width);
    a = int'(addr % 4);
    nbytes = 1 << (wcode % 4);
    if (wcode == 3 || wcode >= 6 || (a % nbytes) != 0) begin
      e.lat = 1;
      e.err = 2'b01;
      return e;
    end
    e.strb = we ? 4'(((1 << nbytes) - 1) << a) : 4'h0;
    if (nbytes == 1)      e.wexp = (wdata % 256) * 32'h0101_0101;
    else if (nbytes == 2) e.wexp = (wdata % 65536) * 32'h0001_0001;
    else                  e.wexp = wdata;
    need = rdy + 1 + (we ? 0 : rv + 1);
    if (need > TO) begin
      e.lat = TO + 1;
      e.err = 2'b10;
      return e;
    end
    e.lat = need + 1;
    if (!we) begin
      v = rdata >> (8 * a);
      if (nbytes == 1) begin
        v = v % 256;
        if (wcode == 0 && v >= 128) v = v - 32'd256;
      end else if (nbytes == 2) begin
        v = v % 65536;
        if (wcode == 1 && v >= 32768) v = v - 32'd65536;
      end
      e.data = v;
    end
    return e;
  endfunction

  // Starts in IDLE at posedge+1; plays one access with the given memory delays and checks it.
  task automatic run_and_check(input string tag, input vec_t t);
    int lat, n_req, n_wait;
    logic saw_req, stable;
    logic [31:0] o_data, o_addr, o_wdata;
    logic [1:0]  o_err;
    logic [3:0]  o_strb;
    logic        o_we;
    lat = -1; n_req = 0; n_wait = 0; saw_req = 1'b0; stable = 1'b1;
    o_data = '0; o_addr = '0; o_wdata = '0; o_err = '0; o_strb = '0; o_we = 1'b0;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = t.we; req_width = t.width; req_addr = t.addr;
    req_wdata = t.wdata; mem_rdata = t.rdata;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      next_cycle();
      req_valid = 1'b0; req_wdata = 32'h5A5A_5A5A; mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (resp_valid) begin
        lat = cyc; o_data = resp_data; o_err = resp_err;
      end else if (mem_valid) begin
        if (!saw_req) begin
          o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_wstrb !== o_strb ||
                     mem_wdata !== o_wdata || mem_we !== o_we) begin
          stable = 1'b0;
        end
        saw_req = 1'b1;
        if (n_req == t.rdy) mem_ready = 1'b1;
        n_req++;
      end else if (busy) begin
        if (n_wait == t.rv) mem_rvalid = 1'b1;
        n_wait++;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(t.lat));
    check({tag, " resp_err"}, 32'(o_err), 32'(t.err));
    check({tag, " resp_data"}, o_data, t.data);
    if (t.err == 2'b01) begin
      check({tag, " no mem access"}, 32'(saw_req), 32'd0);
    end else begin
      check({tag, " mem_valid seen"}, 32'(saw_req), 32'd1);
      check({tag, " mem_addr"}, o_addr, {t.addr[31:2], 2'b00});
      check({tag, " mem_we"}, 32'(o_we), 32'(t.we));
      check({tag, " mem_wstrb"}, 32'(o_strb), 32'(t.strb));
      check({tag, " req stable"}, 32'(stable), 32'd1);
      if (t.we) check({tag, " mem_wdata"}, o_wdata, t.wexp);
    end
    next_cycle();
    check({tag, " single pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    vec_t e;
    int accepts, resps;
    logic rwe;
    logic [2:0] rw;
    int rdy, rv;

    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0, 0, 3, 2'b00, 32'hFFFF_FF80, 4'h0, 32'h0};
    vecs[1]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h9ABC_1234, 0, 0, 3, 2'b00, 32'h0000_9ABC, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h9ABC_1234, 0, 0, 1, 2'b01, 32'h0, 4'h0, 32'h0};
    vecs[3]  = '{1'b1, 3'b000, 32'h0000_0002, 32'h0000_00A5, 32'h0, 0, 0, 2, 2'b00, 32'h0, 4'b0100, 32'hA5A5_A5A5};
    vecs[4]  = '{1'b1, 3'b000, 32'h0000_0002, 32'h0000_00A5, 32'h0, 3, 0, 5, 2'b00, 32'h0, 4'b0100, 32'hA5A5_A5A5};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 99, 9, 2'b10, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, 6, 9, 2'b00, 32'hDEAD_BEEF, 4'h0, 32'h0};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0003, 32'h1234, 32'h0, 0, 0, 1, 2'b01, 32'h0, 4'h0, 32'h0};
    vecs[8]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h1111_1111, 0, 0, 1, 2'b01, 32'h0, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0, 8, 0, 9, 2'b10, 32'h0, 4'b1111, 32'h1234_5678};
    vecs[10] = '{1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 0, 3, 2'b00, 32'hFFFF_8001, 4'h0, 32'h0};
    vecs[11] = '{1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F000, 0, 0, 3, 2'b00, 32'h0000_00F0, 4'h0, 32'h0};
    vecs[12] = '{1'b1, 3'b001, 32'h0000_0002, 32'h0000_BEEF, 32'h0, 1, 0, 3, 2'b00, 32'h0, 4'b1100, 32'hBEEF_BEEF};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'h0123_4567, 2, 1, 6, 2'b00, 32'h0123_4567, 4'h0, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = '0; req_addr = '0;
    req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) next_cycle();
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem_valid", 32'(mem_valid), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_data", resp_data, 32'h0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) run_and_check($sformatf("vec%0d", i), vecs[i]);

    for (int k = 0; k < 40; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rw  = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      rv  = ($urandom_range(0, 7) == 0) ? 9 : int'($urandom_range(0, 3));
      e = ref_model(rwe, rw, $urandom, $urandom, $urandom, rdy, rv);
      run_and_check($sformatf("rand%0d", k), e);
    end

    // Reset while waiting for read data; a late rvalid must not produce a response.
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 32'h20;
    next_cycle();
    req_valid = 1'b0; mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    check("wait state busy", 32'(busy), 32'd1);
    check("wait state mem_valid", 32'(mem_valid), 32'd0);
    rst = 1'b1;
    next_cycle();
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid mem_valid", 32'(mem_valid), 32'd0);
    check("rst mid resp_valid", 32'(resp_valid), 32'd0);
    check("rst mid req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    next_cycle();
    mem_rvalid = 1'b0;
    check("stray rvalid resp_valid", 32'(resp_valid), 32'd0);
    check("stray rvalid busy", 32'(busy), 32'd0);
    next_cycle();
    check("stray rvalid later", 32'(resp_valid | busy), 32'd0);

    // Back-to-back loads with req_valid held high.
    accepts = 0; resps = 0;
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b000; req_addr = 32'h1;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_7F00;
    for (int c = 0; c < 8; c++) begin
      if (req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        check("b2b ready low in done", 32'(req_ready), 32'd0);
        check("b2b resp_data", resp_data, 32'h0000_007F);
      end
      next_cycle();
    end
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    check("b2b accepts", 32'(accepts), 32'd2);
    check("b2b responses", 32'(resps), 32'd2);
    next_cycle();
    check("b2b idle after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
